// File: rtl/trace_pkg.sv
// Shared types and helpers for the instruction trace monitor.
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HALTED  = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    localparam logic [31:0] DEFAULT_HALT_WORD = 32'h0000_000C;

    function automatic int entry_w(input int tsw, input int iw);
        return tsw + iw;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Circular trace buffer with FWFT head, occupancy count and wrap/drop overflow policy.
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 48
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       wrap,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          do_pop;
    logic          wr_ok;
    logic          overwrite;
    logic          grow;

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign do_pop = pop && !empty && !clear;

    // A same-cycle pop frees a slot, so a full buffer only overflows without one.
    assign wr_ok     = push && !clear && (!full || do_pop || wrap);
    assign overwrite = push && !clear && full && !do_pop && wrap;
    assign grow      = wr_ok && !overwrite;

    assign dout = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop || overwrite) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (grow && !do_pop) begin
                count <= count + 1'b1;
            end else if (!grow && do_pop) begin
                count <= count - 1'b1;
            end
            if (push && full && !do_pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_trace_monitor.sv
// Run-control FSM, cycle counter and halt/timeout detection that feeds a timestamped trace buffer.
module instr_trace_monitor
    import trace_pkg::*;
#(
    parameter int              IW           = 32,
    parameter int              DEPTH        = 16,
    parameter int              TSW          = 16,
    parameter int              HALT_CYCLES  = 8,
    parameter int              TIMEOUT      = 400,
    parameter logic [IW-1:0]   HALT_WORD    = IW'(DEFAULT_HALT_WORD),
    parameter bit              HALT_WORD_EN = 1'b1
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       clear,
    input  logic                       log_all,
    input  logic                       wrap,
    input  logic [IW-1:0]              instr_in,
    input  logic                       rd_en,
    output logic [TSW+IW-1:0]          rd_data,
    output logic                       rd_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       running,
    output logic                       halted,
    output logic                       timed_out,
    output logic                       overflow,
    output logic                       led,
    output state_t                     fsm_state
);

    localparam int ENTRY_W = entry_w(TSW, IW);
    localparam int SW      = $clog2(HALT_CYCLES);

    state_t          state;
    state_t          nxt;
    logic [TSW-1:0]  cyc;
    logic [SW-1:0]   stable;
    logic [IW-1:0]   last_instr;
    logic            in_run;
    logic            first;
    logic            same;
    logic            halt_hit;
    logic            timeout_hit;
    logic            wr_en;
    logic [ENTRY_W-1:0] entry;

    assign fsm_state = state;
    assign in_run    = (state == ST_RUN);
    // cyc is zeroed on entry to RUN, so zero marks the first sample of a run.
    assign first     = (cyc == '0);
    assign same      = !first && (instr_in == last_instr);

    assign halt_hit    = in_run && ((same && (stable == SW'(HALT_CYCLES-1))) ||
                                    (HALT_WORD_EN && (instr_in == HALT_WORD)));
    assign timeout_hit = in_run && (cyc == TSW'(TIMEOUT-1));

    assign wr_en = in_run && (first || log_all || (instr_in != last_instr));
    assign entry = {cyc, instr_in};

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:    if (enable) nxt = ST_RUN;
            ST_RUN: begin
                if (halt_hit) begin
                    nxt = ST_HALTED;
                end else if (timeout_hit) begin
                    nxt = ST_TIMEOUT;
                end
            end
            default:    nxt = state;
        endcase
        if (clear) begin
            nxt = ST_IDLE;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cyc        <= '0;
            stable     <= '0;
            last_instr <= '0;
            running    <= 1'b0;
            halted     <= 1'b0;
            timed_out  <= 1'b0;
            led        <= 1'b0;
        end else begin
            state     <= nxt;
            running   <= (nxt == ST_RUN);
            halted    <= (nxt == ST_HALTED);
            timed_out <= (nxt == ST_TIMEOUT);
            led       <= (nxt == ST_HALTED) || (nxt == ST_TIMEOUT);
            if (state == ST_IDLE && nxt == ST_RUN) begin
                cyc    <= '0;
                stable <= '0;
            end else if (in_run) begin
                cyc        <= cyc + 1'b1;
                stable     <= same ? stable + 1'b1 : '0;
                last_instr <= instr_in;
            end
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk      (CLK),
        .rst_n    (reset),
        .clear    (clear),
        .wrap     (wrap),
        .push     (wr_en),
        .din      (entry),
        .pop      (rd_en),
        .dout     (rd_data),
        .empty    (rd_empty),
        .count    (count),
        .overflow (overflow)
    );

endmodule

// File: tb/tb_instr_trace_monitor.sv
// Directed bench for instr_trace_monitor with a queue-based trace model.
module tb_instr_trace_monitor;
    import trace_pkg::*;

    localparam int IW    = 32;
    localparam int DEPTH = 4;
    localparam int TSW   = 16;
    localparam int EW    = TSW + IW;
    localparam logic [IW-1:0] HW = 32'h0000_000C;

    logic           CLK = 1'b0;
    logic           reset = 1'b0;
    logic           enable = 1'b0;
    logic           clear = 1'b0;
    logic           log_all = 1'b0;
    logic           wrap = 1'b0;
    logic           rd_en = 1'b0;
    logic [IW-1:0]  instr_in = '0;
    logic [EW-1:0]  rd_data;
    logic           rd_empty;
    logic [2:0]     count;
    logic           running;
    logic           halted;
    logic           timed_out;
    logic           overflow;
    logic           led;
    state_t         fsm_state;

    instr_trace_monitor #(
        .IW    (IW),
        .DEPTH (DEPTH),
        .TSW   (TSW)
    ) dut (
        .CLK       (CLK),
        .reset     (reset),
        .enable    (enable),
        .clear     (clear),
        .log_all   (log_all),
        .wrap      (wrap),
        .instr_in  (instr_in),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_empty  (rd_empty),
        .count     (count),
        .running   (running),
        .halted    (halted),
        .timed_out (timed_out),
        .overflow  (overflow),
        .led       (led),
        .fsm_state (fsm_state)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int m_cyc;
    logic [IW-1:0] m_last;
    logic [EW-1:0] exp_q[$];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input logic la, input logic wr);
        log_all = la;
        wrap    = wr;
        enable  = 1'b1;
        tick();
        enable  = 1'b0;
        m_cyc   = 0;
        chk("running_on_start", 64'(running), 64'd1);
    endtask

    // Drive one RUN-cycle sample; the model decides whether it is logged.
    task automatic sample(input logic [IW-1:0] instr, input logic pop);
        logic [EW-1:0] e;
        instr_in = instr;
        rd_en    = pop;
        if (pop && exp_q.size() > 0) begin
            chk("pop_head", 64'(rd_data), 64'(exp_q[0]));
            void'(exp_q.pop_front());
        end
        if (m_cyc == 0 || log_all || instr != m_last) begin
            e = {TSW'(m_cyc), instr};
            if (exp_q.size() >= DEPTH) begin
                if (wrap) begin
                    void'(exp_q.pop_front());
                    exp_q.push_back(e);
                end
            end else begin
                exp_q.push_back(e);
            end
        end
        m_last = instr;
        m_cyc++;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic drain();
        chk("count_before_drain", 64'(count), 64'(exp_q.size()));
        while (exp_q.size() > 0) begin
            chk("rd_empty_while_data", 64'(rd_empty), 64'd0);
            chk("rd_data", 64'(rd_data), 64'(exp_q[0]));
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
            void'(exp_q.pop_front());
        end
        chk("rd_empty_after_drain", 64'(rd_empty), 64'd1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("count_after_empty_pop", 64'(count), 64'd0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        exp_q.delete();
        chk("clear_state", 64'(fsm_state), 64'(ST_IDLE));
        chk("clear_count", 64'(count), 64'd0);
        chk("clear_flags", 64'({halted, timed_out, overflow, led, running}), 64'd0);
        chk("clear_empty", 64'(rd_empty), 64'd1);
    endtask

    initial begin
        // Reset values
        #12;
        chk("reset_state", 64'(fsm_state), 64'(ST_IDLE));
        chk("reset_flags", 64'({running, halted, timed_out, overflow, led}), 64'd0);
        chk("reset_empty", 64'(rd_empty), 64'd1);
        chk("reset_rd_data", 64'(rd_data), 64'd0);
        chk("reset_count", 64'(count), 64'd0);
        reset = 1'b1;
        tick();

        // Change-only logging, then stability halt on the held word
        start_run(1'b0, 1'b1);
        sample(32'h11, 1'b0);
        sample(32'h11, 1'b0);
        sample(32'h22, 1'b0);
        sample(32'h22, 1'b0);
        sample(32'h22, 1'b0);
        sample(32'h2008_0001, 1'b0);
        for (int i = 0; i < 7; i++) sample(32'h2008_0001, 1'b0);
        chk("not_halted_after_7", 64'(halted), 64'd0);
        sample(32'h2008_0001, 1'b0);
        chk("halted_after_8", 64'(halted), 64'd1);
        chk("halt_led", 64'(led), 64'd1);
        chk("halt_not_running", 64'(running), 64'd0);
        chk("halt_state", 64'(fsm_state), 64'(ST_HALTED));
        instr_in = 32'h55;
        tick();
        instr_in = 32'h66;
        tick();
        chk("no_log_after_halt", 64'(count), 64'd3);
        chk("halt_sticky", 64'(halted), 64'd1);
        drain();
        do_clear();

        // Asynchronous reset in the middle of a run
        start_run(1'b1, 1'b1);
        for (int i = 1; i <= 5; i++) sample(IW'(i), 1'b0);
        chk("pre_reset_count", 64'(count), 64'd4);
        #2 reset = 1'b0;
        #1;
        chk("midreset_state", 64'(fsm_state), 64'(ST_IDLE));
        chk("midreset_flags", 64'({running, halted, timed_out, overflow, led}), 64'd0);
        chk("midreset_empty", 64'(rd_empty), 64'd1);
        chk("midreset_count", 64'(count), 64'd0);
        chk("midreset_rd_data", 64'(rd_data), 64'd0);
        #2 reset = 1'b1;
        exp_q.delete();
        tick();

        // Full buffer, wrap=1 overwrites oldest; halt word ends the run
        start_run(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) sample(32'h31 + IW'(i), 1'b0);
        sample(HW, 1'b0);
        chk("wrap_overflow", 64'(overflow), 64'd1);
        chk("wrap_halted", 64'(halted), 64'd1);
        drain();
        do_clear();

        // Full buffer, wrap=0 drops new entries
        start_run(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) sample(32'h31 + IW'(i), 1'b0);
        sample(HW, 1'b0);
        chk("drop_overflow", 64'(overflow), 64'd1);
        drain();
        do_clear();

        // Same-cycle pop and push on a full buffer
        start_run(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) sample(32'h41 + IW'(i), 1'b0);
        chk("full_count", 64'(count), 64'd4);
        sample(32'h45, 1'b1);
        chk("poppush_count", 64'(count), 64'd4);
        chk("poppush_no_overflow", 64'(overflow), 64'd0);
        sample(HW, 1'b1);
        chk("poppush_halted", 64'(halted), 64'd1);
        chk("poppush_no_overflow2", 64'(overflow), 64'd0);
        drain();
        do_clear();

        // Halt word on the third RUN cycle
        start_run(1'b0, 1'b1);
        sample(32'h1, 1'b0);
        sample(32'h2, 1'b0);
        chk("hw_not_yet", 64'(halted), 64'd0);
        sample(HW, 1'b0);
        chk("hw_halted", 64'(halted), 64'd1);
        chk("hw_led", 64'(led), 64'd1);
        drain();
        do_clear();

        // Cycle-budget timeout with an ever-changing instruction stream
        start_run(1'b0, 1'b1);
        for (int i = 0; i < 399; i++) sample(32'h100 + IW'(i), 1'b0);
        chk("to_still_running", 64'(running), 64'd1);
        chk("to_not_yet", 64'(timed_out), 64'd0);
        sample(32'h100 + 32'd399, 1'b0);
        chk("to_timed_out", 64'(timed_out), 64'd1);
        chk("to_state", 64'(fsm_state), 64'(ST_TIMEOUT));
        chk("to_led", 64'(led), 64'd1);
        chk("to_not_halted", 64'(halted), 64'd0);
        chk("to_overflow", 64'(overflow), 64'd1);
        drain();
        do_clear();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_trace_monitor.md
# instr_trace_monitor

Synthesizable run-control and instruction-trace block that sits beside `computer` and takes the place of the fixed-duration simulation harness. It samples `data_out_instruction` every clock and records timestamped entries into a parametrised circular buffer. It detects program halt (stable fetch or a halt word) and a cycle-budget timeout, and exposes a FWFT readout port so the trace can be drained in simulation or on hardware.

## Interface
- `IW`, 32: instruction width.
- `DEPTH`, 16: trace entries; power of two, ≥2.
- `TSW`, 16: timestamp/cycle-counter width.
- `HALT_CYCLES`, 8: consecutive identical samples that declare halt; ≥2.
- `TIMEOUT`, 400: cycle budget in RUN; must be < 2^TSW.
- `HALT_WORD`, 32'h0000_000C: instruction that halts immediately.
- `HALT_WORD_EN`, 1: enables halt-word detection.

Ports:
- `CLK`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  level; IDLE→RUN.
- `clear`  in  1  one-cycle pulse; any state→IDLE; empties buffer and clears flags.
- `log_all`  in  1  1 = log every RUN cycle; 0 = log on change only.
- `wrap`  in  1  1 = overwrite oldest entry when full; 0 = drop the new entry.
- `instr_in`  in  IW  from `computer.data_out_instruction`.
- `rd_en`  in  1  pop the head entry.
- `rd_data`  out  TSW+IW  head entry {timestamp, instr}; FWFT.
- `rd_empty`  out  1  buffer empty.
- `count`  out  $clog2(DEPTH+1)  entries held.
- `running`, `halted`, `timed_out`, `overflow`  out  1 each  status.
- `led`  out  1  `halted` OR `timed_out`.

## Operation
- States: IDLE, RUN, HALTED, TIMEOUT.
- IDLE→RUN when `enable`=1.
- RUN→HALTED on a halt condition. RUN→TIMEOUT when `cyc`==TIMEOUT-1. If both occur in the same cycle, HALTED wins.
- HALTED and TIMEOUT are sticky until `clear`.
- `clear` has priority over every transition and over a same-cycle write.
- Cycle counter `cyc`:
  - Zeroed on entry to RUN.
  - Increments every RUN cycle.
  - Holds its value outside RUN.
- Capture (RUN only). An entry {cyc, instr_in} is written when any of these holds:
  - It is the first RUN cycle.
  - `log_all`=1.
  - `instr_in` differs from `last_instr`.
- `last_instr` is updated every RUN cycle.
- Halt conditions:
  - `stable` counts consecutive RUN cycles with `instr_in`==`last_instr`; it resets to 0 on a change. Halt when `stable`==HALT_CYCLES-1 and the current sample is still equal.
  - Halt also when HALT_WORD_EN=1 and `instr_in`==HALT_WORD.
  - The halting cycle's sample is still logged, subject to the capture rule.
- Full buffer with a write pending:
  - `wrap`=1: overwrite the oldest entry (read pointer advances), set `overflow`.
  - `wrap`=0: discard the new entry, set `overflow`.
- Full buffer with same-cycle pop and push: both happen, `count` is unchanged, `overflow` is not set.
- `rd_en` while empty is ignored. Popping is allowed in every state.
- Pointers wrap modulo DEPTH.

## Timing
- Reset (asynchronous, `reset`=0): state=IDLE; `cyc`, `stable`, `last_instr`, pointers, `count`, and all flags = 0; `rd_empty`=1; `rd_data`=0.
- Write latency: an entry sampled at edge n is visible on `rd_data` and in `count` after edge n.
- `rd_data` is combinational from the head entry.
- A pop at edge n exposes the next entry after edge n.
- Status outputs are registered and reflect the state after each edge.
- `running`=1 exactly while state=RUN.
- Reset asserted mid-RUN aborts immediately. Buffer contents are lost.

## Structure
- `trace_pkg`:
  - state enum.
  - `ENTRY_W = TSW+IW` helper function.
  - default HALT_WORD constant.
- Sub-module `trace_fifo`: parametrised DEPTH×ENTRY_W circular buffer with wrap/drop policy and `count`, instantiated once.
- The top level holds the FSM, counters, and halt/timeout logic.

## Test plan
- Reset mid-RUN with 5 entries logged → all outputs return to reset values within the reset-low window; `rd_empty`=1.
- `log_all`=0, instr sequence A,A,B,B,B,C (HALT_WORD_EN=0) → 3 entries: {0,A}, {2,B}, {5,C}.
- Instr held at 0x20080001 after the first sample, HALT_CYCLES=8 → `halted`=1 after the 8th identical sample; `led`=1; later samples not logged.
- Changing instr every cycle with TIMEOUT=400 → TIMEOUT state on the edge where `cyc`=399.
- DEPTH=4, `log_all`=1, 6 RUN cycles:
  - `wrap`=1 → entries cyc 2–5, `overflow`=1.
  - `wrap`=0 → entries cyc 0–3, `overflow`=1.
  - Pop+push when full → `count`=4, `overflow`=0.
- HALT_WORD_EN=1 with `instr_in`=0x0000000C on the third RUN cycle → HALTED after that edge; `clear` → IDLE, `count`=0, flags 0.
